// File: rtl/fwd_hazard_ctrl_if.sv
// Decode/bypass bundle between the decoder side and the hazard controller.
// The master drives the decode slot; the slave returns selects and holds.
interface fwd_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int SELW   = 2
);
    logic              ext_stall;
    logic              dec_valid;
    logic [REG_AW-1:0] dec_rs1;
    logic [REG_AW-1:0] dec_rs2;
    logic              dec_rs1_used;
    logic              dec_rs2_used;
    logic [REG_AW-1:0] dec_rd;
    logic              dec_we;
    logic              dec_is_load;
    logic              redirect;
    logic              stall;
    logic              kill_dec;
    logic [SELW-1:0]   fwd_sel_a;
    logic [SELW-1:0]   fwd_sel_b;
    logic              wb_we;
    logic [REG_AW-1:0] wb_rd;
    logic              busy;

    modport master (
        output ext_stall, dec_valid, dec_rs1, dec_rs2,
        output dec_rs1_used, dec_rs2_used, dec_rd,
        output dec_we, dec_is_load, redirect,
        input  stall, kill_dec, fwd_sel_a, fwd_sel_b,
        input  wb_we, wb_rd, busy
    );

    modport slave (
        input  ext_stall, dec_valid, dec_rs1, dec_rs2,
        input  dec_rs1_used, dec_rs2_used, dec_rd,
        input  dec_we, dec_is_load, redirect,
        output stall, kill_dec, fwd_sel_a, fwd_sel_b,
        output wb_we, wb_rd, busy
    );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Bypass/hazard controller: destination-tag scoreboard for DEPTH stages.
// Drives operand forward selects, load-use stall, redirect kill, writeback.
module fwd_hazard_ctrl #(
    parameter int REG_AW      = 5,
    parameter int DEPTH       = 3,
    parameter int LOAD_LAT    = 1,
    parameter int KILL_CYCLES = 1,
    parameter int SELW        = $clog2(DEPTH + 1)
) (
    input logic              clk,
    input logic              reset,
    fwd_hazard_ctrl_if.slave bus
);
    typedef struct packed {
        logic              v;
        logic              we;
        logic [REG_AW-1:0] rd;
        logic              ld;
    } entry_t;

    entry_t     ent_q [DEPTH];
    logic [2:0] kc_q;

    logic            kill_c;
    logic            dv;
    logic            stall_c;
    logic            haz_a;
    logic            haz_b;
    logic [SELW-1:0] sel_a;
    logic [SELW-1:0] sel_b;
    logic            busy_c;

    function automatic logic hit(entry_t e, logic [REG_AW-1:0] s,
                                 logic used);
        return e.v & e.we & (e.rd == s) & (s != '0) & used;
    endfunction

    assign kill_c  = bus.redirect | (kc_q != 3'd0);
    assign dv      = bus.dec_valid & ~kill_c;
    assign stall_c = dv & (haz_a | haz_b) & ~bus.redirect;

    // Youngest matching producer wins; an unready load flags a hazard.
    always_comb begin
        sel_a = '0;
        haz_a = 1'b0;
        sel_b = '0;
        haz_b = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (hit(ent_q[k], bus.dec_rs1, bus.dec_rs1_used)) begin
                haz_a = ent_q[k].ld && (k < LOAD_LAT);
                sel_a = haz_a ? '0 : SELW'(k + 1);
            end
            if (hit(ent_q[k], bus.dec_rs2, bus.dec_rs2_used)) begin
                haz_b = ent_q[k].ld && (k < LOAD_LAT);
                sel_b = haz_b ? '0 : SELW'(k + 1);
            end
        end
    end

    // Pipeline occupancy is the OR of all valid bits.
    always_comb begin
        busy_c = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            busy_c = busy_c | ent_q[k].v;
        end
    end

    // Scoreboard shift and kill counter; freeze wins, then redirect, then stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                ent_q[k] <= '0;
            end
            kc_q <= 3'd0;
        end else if (!bus.ext_stall) begin
            for (int k = 1; k < DEPTH; k++) begin
                ent_q[k] <= ent_q[k-1];
            end
            if (bus.redirect) begin
                ent_q[0] <= '0;
                kc_q     <= 3'(KILL_CYCLES - 1);
            end else if (stall_c) begin
                ent_q[0] <= '0;
            end else begin
                ent_q[0] <= '{v:  dv,
                              we: bus.dec_we & dv,
                              rd: bus.dec_rd,
                              ld: bus.dec_is_load & dv};
                if (kc_q != 3'd0) begin
                    kc_q <= kc_q - 3'd1;
                end
            end
        end
    end

    assign bus.stall     = stall_c;
    assign bus.kill_dec  = kill_c;
    assign bus.fwd_sel_a = sel_a;
    assign bus.fwd_sel_b = sel_b;
    assign bus.wb_we     = ent_q[DEPTH-1].v & ent_q[DEPTH-1].we;
    assign bus.wb_rd     = ent_q[DEPTH-1].rd;
    assign bus.busy      = busy_c;
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed scenarios then random traffic,
// checked against an age-ordered queue model of in-flight instructions.
module tb_fwd_hazard_ctrl;
    localparam int REG_AW      = 5;
    localparam int DEPTH       = 3;
    localparam int LOAD_LAT    = 2;
    localparam int KILL_CYCLES = 2;
    localparam int SELW        = $clog2(DEPTH + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fwd_hazard_ctrl_if #(.REG_AW(REG_AW), .SELW(SELW)) bus ();

    fwd_hazard_ctrl #(
        .REG_AW(REG_AW),
        .DEPTH(DEPTH),
        .LOAD_LAT(LOAD_LAT),
        .KILL_CYCLES(KILL_CYCLES),
        .SELW(SELW)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .bus(bus)
    );

    typedef struct {
        bit v;
        bit we;
        bit ld;
        int rd;
    } slot_t;

    // pipe[age]: age 0 is the instruction that most recently left decode.
    slot_t pipe[$];
    int    kill_left;
    int    n_vec = 0;
    int    n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    function automatic void model_reset();
        pipe.delete();
        repeat (DEPTH) pipe.push_back('{v: 0, we: 0, ld: 0, rd: 0});
        kill_left = 0;
    endfunction

    // A load's data can be bypassed once it has aged LOAD_LAT slots.
    function automatic void src_exp(int s, bit used, output int sel,
                                    output bit haz);
        sel = 0;
        haz = 0;
        if (!used || s == 0) return;
        for (int age = 0; age < DEPTH; age++) begin
            if (pipe[age].v && pipe[age].we && pipe[age].rd == s) begin
                if (pipe[age].ld && age < LOAD_LAT) haz = 1;
                else sel = age + 1;
                return;
            end
        end
    endfunction

    function automatic bit exp_kill();
        return bus.redirect || kill_left > 0;
    endfunction

    function automatic bit exp_stall();
        int sa, sb;
        bit ha, hb, dv;
        dv = bus.dec_valid && !exp_kill();
        src_exp(int'(bus.dec_rs1), bus.dec_rs1_used, sa, ha);
        src_exp(int'(bus.dec_rs2), bus.dec_rs2_used, sb, hb);
        return dv && (ha || hb) && !bus.redirect;
    endfunction

    task automatic settle();
        int sa, sb;
        bit ha, hb, wbwe, any;
        #2;
        src_exp(int'(bus.dec_rs1), bus.dec_rs1_used, sa, ha);
        src_exp(int'(bus.dec_rs2), bus.dec_rs2_used, sb, hb);
        wbwe = pipe[DEPTH-1].v && pipe[DEPTH-1].we;
        any  = 0;
        foreach (pipe[i]) any |= pipe[i].v;
        check("stall", 32'(bus.stall), 32'(exp_stall()));
        check("kill_dec", 32'(bus.kill_dec), 32'(exp_kill()));
        check("fwd_sel_a", 32'(bus.fwd_sel_a), sa);
        check("fwd_sel_b", 32'(bus.fwd_sel_b), sb);
        check("wb_we", 32'(bus.wb_we), 32'(wbwe));
        if (wbwe) check("wb_rd", 32'(bus.wb_rd), pipe[DEPTH-1].rd);
        check("busy", 32'(bus.busy), 32'(any));
    endtask

    task automatic tick();
        bit    stl, dv;
        slot_t s;
        stl = exp_stall();
        dv  = bus.dec_valid && !exp_kill();
        if (!bus.ext_stall) begin
            s = '{v: 0, we: 0, ld: 0, rd: 0};
            if (!bus.redirect && !stl)
                s = '{v: dv, we: dv && bus.dec_we,
                      ld: dv && bus.dec_is_load, rd: int'(bus.dec_rd)};
            pipe.push_front(s);
            void'(pipe.pop_back());
            if (bus.redirect) kill_left = KILL_CYCLES - 1;
            else if (!stl && kill_left > 0) kill_left--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    task automatic set_idle();
        bus.ext_stall    = 1'b0;
        bus.dec_valid    = 1'b0;
        bus.dec_rs1      = '0;
        bus.dec_rs2      = '0;
        bus.dec_rs1_used = 1'b0;
        bus.dec_rs2_used = 1'b0;
        bus.dec_rd       = '0;
        bus.dec_we       = 1'b0;
        bus.dec_is_load  = 1'b0;
        bus.redirect     = 1'b0;
    endtask

    task automatic issue(input int rd, input bit we, input bit ld,
                         input int rs1, input bit u1,
                         input int rs2, input bit u2);
        set_idle();
        bus.dec_valid    = 1'b1;
        bus.dec_rd       = REG_AW'(rd);
        bus.dec_we       = we;
        bus.dec_is_load  = ld;
        bus.dec_rs1      = REG_AW'(rs1);
        bus.dec_rs1_used = u1;
        bus.dec_rs2      = REG_AW'(rs2);
        bus.dec_rs2_used = u2;
    endtask

    initial begin
        set_idle();
        model_reset();
        @(posedge clk);
        #1;
        step();
        rst_n = 1'b1;
        repeat (5) step();

        // ALU back-to-back forward, then writeback of x5
        issue(5, 1, 0, 1, 1, 2, 1);
        step();
        issue(6, 1, 0, 5, 1, 0, 0);
        settle();
        check("alu_fwd_a", 32'(bus.fwd_sel_a), 1);
        check("alu_nostall", 32'(bus.stall), 0);
        tick();
        set_idle();
        step();
        settle();
        check("wb_we_x5", 32'(bus.wb_we), 1);
        check("wb_rd_x5", 32'(bus.wb_rd), 5);
        tick();
        repeat (2) step();

        // load-use back-to-back: LOAD_LAT stall cycles
        issue(7, 1, 1, 0, 0, 0, 0);
        step();
        issue(8, 1, 0, 0, 0, 7, 1);
        settle();
        check("lu_stall_0", 32'(bus.stall), 1);
        tick();
        settle();
        check("lu_stall_1", 32'(bus.stall), 1);
        tick();
        settle();
        check("lu_release", 32'(bus.stall), 0);
        check("lu_fwd_b", 32'(bus.fwd_sel_b), 3);
        tick();

        // load with one gap: one stall cycle
        issue(9, 1, 1, 0, 0, 0, 0);
        step();
        set_idle();
        step();
        issue(10, 1, 0, 9, 1, 0, 0);
        settle();
        check("lu_gap_stall", 32'(bus.stall), 1);
        tick();
        settle();
        check("lu_gap_release", 32'(bus.stall), 0);
        check("lu_gap_fwd_a", 32'(bus.fwd_sel_a), 3);
        tick();
        set_idle();
        repeat (DEPTH) step();

        // single redirect kills KILL_CYCLES slots, none write back
        issue(11, 1, 0, 0, 0, 0, 0);
        bus.redirect = 1'b1;
        settle();
        check("rd1_kill_0", 32'(bus.kill_dec), 1);
        tick();
        issue(12, 1, 0, 0, 0, 0, 0);
        settle();
        check("rd1_kill_1", 32'(bus.kill_dec), 1);
        tick();
        issue(13, 1, 0, 0, 0, 0, 0);
        settle();
        check("rd1_kill_end", 32'(bus.kill_dec), 0);
        tick();
        set_idle();
        settle();
        check("rd1_no_wb_0", 32'(bus.wb_we), 0);
        tick();
        settle();
        check("rd1_no_wb_1", 32'(bus.wb_we), 0);
        tick();
        settle();
        check("rd1_wb_x13", 32'(bus.wb_we), 1);
        check("rd1_wb_rd", 32'(bus.wb_rd), 13);
        tick();

        // redirect during kill reloads the counter
        issue(20, 1, 0, 0, 0, 0, 0);
        bus.redirect = 1'b1;
        step();
        bus.redirect = 1'b1;
        settle();
        check("rd2_kill_1", 32'(bus.kill_dec), 1);
        tick();
        bus.redirect = 1'b0;
        settle();
        check("rd2_kill_ext", 32'(bus.kill_dec), 1);
        tick();
        settle();
        check("rd2_kill_end", 32'(bus.kill_dec), 0);
        tick();
        set_idle();
        repeat (DEPTH) step();

        // x0 and unused sources never forward or stall
        issue(14, 1, 0, 0, 0, 0, 0);
        step();
        issue(0, 1, 1, 0, 0, 0, 0);
        step();
        issue(15, 1, 0, 0, 1, 14, 0);
        settle();
        check("x0_sel_a", 32'(bus.fwd_sel_a), 0);
        check("unused_sel_b", 32'(bus.fwd_sel_b), 0);
        check("x0_nostall", 32'(bus.stall), 0);
        tick();
        set_idle();
        repeat (DEPTH) step();

        // ext_stall freezes a load-use stall in place
        issue(16, 1, 1, 0, 0, 0, 0);
        step();
        issue(17, 1, 0, 16, 1, 0, 0);
        step();
        bus.ext_stall = 1'b1;
        repeat (3) begin
            settle();
            check("frz_stall", 32'(bus.stall), 1);
            tick();
        end
        bus.ext_stall = 1'b0;
        settle();
        check("frz_after", 32'(bus.stall), 1);
        tick();
        settle();
        check("frz_release", 32'(bus.stall), 0);
        check("frz_fwd_a", 32'(bus.fwd_sel_a), 3);
        tick();

        // asynchronous reset in the middle of a kill window
        issue(18, 1, 0, 0, 0, 0, 0);
        bus.redirect = 1'b1;
        step();
        set_idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_stall", 32'(bus.stall), 0);
        check("rst_kill", 32'(bus.kill_dec), 0);
        check("rst_sel_a", 32'(bus.fwd_sel_a), 0);
        check("rst_sel_b", 32'(bus.fwd_sel_b), 0);
        check("rst_wb_we", 32'(bus.wb_we), 0);
        check("rst_wb_rd", 32'(bus.wb_rd), 0);
        check("rst_busy", 32'(bus.busy), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(19, 1, 0, 0, 0, 0, 0);
        settle();
        check("post_rst_kill", 32'(bus.kill_dec), 0);
        tick();
        set_idle();
        repeat (DEPTH) step();

        // random traffic on a small register set
        repeat (800) begin
            bus.dec_valid    = ($urandom_range(0, 9) < 8);
            bus.dec_rs1      = REG_AW'($urandom_range(0, 7));
            bus.dec_rs2      = REG_AW'($urandom_range(0, 7));
            bus.dec_rs1_used = ($urandom_range(0, 3) != 0);
            bus.dec_rs2_used = ($urandom_range(0, 3) != 0);
            bus.dec_rd       = REG_AW'($urandom_range(0, 7));
            bus.dec_we       = ($urandom_range(0, 4) != 0);
            bus.dec_is_load  = ($urandom_range(0, 9) < 3);
            bus.redirect     = ($urandom_range(0, 15) == 0);
            bus.ext_stall    = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Parametrised bypass and hazard controller for the Riscv151 integer pipeline; successor to the fixed 3-stage control bypass logic.
- Keeps a shift-register scoreboard of destination tags for DEPTH in-flight stages behind decode.
- From that scoreboard it produces:
  - per-operand forward selects;
  - load-use stalls, with configurable load latency;
  - multi-cycle kill after a redirect;
  - the writeback enable and address.
- Sits beside the decoder; its outputs drive the datapath operand muxes and PC/fetch hold.

Parameters:
- REG_AW, 5, register address width.
- DEPTH, 3, number of tracked stages after decode (entry 0 = X, entry DEPTH-1 = writeback); range 2..8.
- LOAD_LAT, 1, lowest entry index whose load data is forwardable; range 0..DEPTH-1.
- KILL_CYCLES, 1, number of decode slots killed per redirect; range 1..4.
- SELW, $clog2(DEPTH+1), forward-select width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ext_stall  in  1  global freeze (cache miss); the whole pipeline holds.
- dec_valid  in  1  decode slot holds a real instruction.
- dec_rs1, dec_rs2  in  REG_AW  decode source registers.
- dec_rs1_used, dec_rs2_used  in  1  the source is actually read.
- dec_rd  in  REG_AW  decode destination register.
- dec_we  in  1  decode instruction writes rd.
- dec_is_load  in  1  decode instruction is a load.
- redirect  in  1  taken branch or jump resolved in entry 0 this cycle.
- stall  out  1  hold PC and decode; insert a bubble into entry 0.
- kill_dec  out  1  decode instruction is squashed (enters entry 0 as a bubble).
- fwd_sel_a, fwd_sel_b  out  SELW  0 = regfile; k+1 = forward from entry k.
- wb_we  out  1  entry DEPTH-1 commits a register write.
- wb_rd  out  REG_AW  commit address.
- busy  out  1  any entry valid.

Behaviour:
- State:
  - DEPTH entries, each holding {v, we, rd, ld}.
  - kill counter kc, width 3.
- Reset (reset=0, asynchronous): all entry v/we/ld = 0, rd = 0, kc = 0. Every output then reads 0; fwd_sel = 0 is regfile.
- Effective decode: dv = dec_valid & ~kill_dec.
- Match: entry k matches source s when v_k & we_k & (rd_k == s) & (s != 0) & s_used.
  - The lowest k (youngest producer) wins.
  - No match gives fwd_sel = 0.
- Forward select (combinational): fwd_sel = k+1 for the winning entry k.
  - If the winner has ld_k = 1 and k < LOAD_LAT, fwd_sel = 0 and a hazard is flagged.
- stall = dv & hazard(rs1 | rs2) & ~redirect. This is combinational.
- kill_dec = redirect | (kc != 0). This is combinational.
- Priority per cycle: ext_stall > redirect > load-use stall > normal advance.
- On each rising edge:
  - ext_stall = 1: all entries and kc hold; outputs are recomputed from the held state.
  - redirect = 1:
    - kc loads KILL_CYCLES-1;
    - the entries shift (entry k+1 <= entry k);
    - entry 0 <= bubble (v = 0).
  - stall = 1: entries shift, entry 0 <= bubble. The decode instruction is re-presented next cycle with fresh matches.
  - Otherwise:
    - entries shift;
    - entry 0 <= {dv, dec_we & dv, dec_rd, dec_is_load & dv};
    - if kc != 0, kc decrements.
- Redirect while kc != 0: kc reloads to KILL_CYCLES-1. A redirect never stacks counts.
- Writeback outputs: wb_we = v & we of entry DEPTH-1; wb_rd = rd of entry DEPTH-1.
  - Writeback sees each instruction exactly DEPTH cycles after it leaves decode, plus any stall cycles.
- A bubble never matches, never writes, and is never forwarded.
- Register x0 never forwards and never stalls.
- Reset asserted mid-stall or mid-kill clears everything immediately. The first cycle after release is a normal advance.
- busy = OR of all v.
- Latency from decode to writeback is DEPTH cycles with no stall. A load-use hazard costs exactly LOAD_LAT - k stall cycles.

Test Plan:
- Reset release, DEPTH=3, no instructions -> all outputs 0 for 5 cycles; busy = 0.
- ADD x5 then ADD x6 with rs1=x5 back-to-back -> fwd_sel_a = 1 (entry 0), stall = 0; x5 reaches wb_we = 1, wb_rd = 5 three cycles after issue.
- LW x7 then ADD rs2=x7, LOAD_LAT=1 -> stall = 1 for exactly 1 cycle, then fwd_sel_b = 2; with LOAD_LAT=2 -> 2 stall cycles, then fwd_sel_b = 3.
- Redirect with KILL_CYCLES=2, redirect pulsed one cycle -> kill_dec = 1 for 2 consecutive cycles; neither slot ever raises wb_we; a second redirect in cycle 2 extends the kill by 1 more cycle.
- Source x0 with x0 "written" in entry 0, plus rs1_used = 0 matching rd -> fwd_sel = 0, no stall.
- ext_stall held 3 cycles during a load-use stall -> entries frozen, stall held at 1; after release, the stall resolves as if uninterrupted. Reset pulse mid-sequence -> all outputs 0 asynchronously.
